fp_result_display: RTL and testbench
====================================

// Module: fp_result_display
// PURPOSE
//  Downstream of the 12-bit-to-float converter. Takes its {S,E,F} result through a
//  valid/ready handshake and holds it in a 1-deep pending buffer.
//  Drives a 4-digit multiplexed common-anode 7-seg display as "<sign><F hex>E<E>".
//  The value shown is F x 2^E. New values reach the display only at a scan-frame
//  boundary, so a frame never shows a mix of old and new digits.
// PARAMETERS
//  REFRESH_DIV  16'd50000  clk cycles each digit is lit (range >= 2)
// PORTS
//  clk       in   1   system clock; all state changes on its rising edge
//  rst       in   1   asynchronous, active-high reset
//  in_valid  in   1   S/E/F carry a new converter result
//  in_ready  out  1   block can accept a result this cycle
//  S         in   1   sign bit from converter
//  E         in   3   exponent from converter
//  F         in   4   significand from converter
//  an        out  4   digit enables, active-low; an[3] = leftmost digit
//  seg       out  7   segments, active-low, {g,f,e,d,c,b,a}
//  updated   out  1   one-cycle pulse when the displayed value changes
// BEHAVIOUR
//  Reset (async, active-high, no clock required):
//   - refresh_cnt = 0, dig_idx = 0
//   - pending_valid = 0, pending = 0, disp{S,E,F} = 0, updated = 0
//   - so an = 4'b1110 and seg = 7'b1000000 ('0')
//  Handshake:
//   - in_ready = !pending_valid (combinational)
//   - Accept when in_valid && in_ready: pending <= {S,E,F}, pending_valid <= 1
//   - in_valid while in_ready = 0 is ignored; upstream must hold it
//  Scan timing:
//   - refresh_cnt counts 0..REFRESH_DIV-1 and wraps to 0
//   - On wrap (tc), dig_idx increments 0->1->2->3->0 (2-bit wrap)
//   - Frame boundary fb = tc && dig_idx == 3
//  Transfer:
//   - On fb with pending_valid: disp <= pending, pending_valid <= 0, updated <= 1
//   - updated is 0 in every other cycle
//   - in_ready rises the cycle after a transfer
//   - Accept and transfer cannot coincide: accept needs pending empty, transfer needs it full
//   - Latency: first accept to visible change is 1 to 4*REFRESH_DIV cycles
//  Digit mapping (an is one-hot low on dig_idx; seg is combinational from dig_idx and disp):
//   - idx3: 7'b0111111 ('-') if S, else 7'b1111111 (blank)
//   - idx2: hex of F
//   - idx1: 'E' = 7'b0000110
//   - idx0: E as 0..7
//  Hex table 0..F:
//   - 0..7: 1000000 1111001 0100100 0110000 0011001 0010010 0000010 1111000
//   - 8..F: 0000000 0010000 0001000 0000011 1000110 0100001 0000110 0001110
//  Mid-operation reset returns everything to reset values and drops any pending value.
//  Checked RTL contains no latches and no derived or gated clocks.
// TESTING (REFRESH_DIV=4; one frame = 16 cycles)
//  1 Reset asserted mid-frame, no clock edge -> an=1110, seg=1000000, in_ready=1,
//    updated=0; all hold until the first clk edge after rst falls.
//  2 Send S=1,E=3,F=B at frame start -> in_ready=0 next cycle, display unchanged
//    until fb, then updated pulses once. Next frame shows idx3=0111111,
//    idx2=0000011, idx1=0000110, idx0=0110000.
//  3 While pending is full, hold in_valid with S=0,E=7,F=F -> no accept.
//    Accepted the cycle after the transfer; shown one frame later as blank,F,E,7.
//  4 Scan order over 2 frames -> an sequence 1110,1101,1011,0111, each held
//    exactly 4 cycles, then repeats.
//  5 Accept S=1,E=5,F=8, assert rst before fb -> value never displayed, updated
//    never pulses, in_ready=1 after reset.
//  6 Random 500 results with random in_valid gaps -> every accepted value is shown in
//    acceptance order. updated count == accepts; none lost, none duplicated.

Source files
------------

// File: rtl/fp_result_display.sv
`default_nettype none
// ============================================================================
//  Module   : fp_result_display
//  Purpose  : Buffers one {S,E,F} converter result and shows it on a 4-digit
//             multiplexed common-anode 7-seg display as "<sign><F>E<E>".
//  Revision : 1.0  initial release
// ============================================================================
module fp_result_display #(
  parameter int unsigned REFRESH_DIV = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       S,
  input  logic [2:0] E,
  input  logic [3:0] F,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       updated
);

  localparam int unsigned      CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] c_seg_minus = 7'b0111111;
  localparam logic [6:0] c_seg_blank = 7'b1111111;
  localparam logic [6:0] c_seg_e     = 7'b0000110;

  logic [CNT_W-1:0] r_refresh_cnt;
  logic [1:0]       r_dig_idx;
  logic             r_pend_valid;
  logic [7:0]       r_pend;
  logic             r_disp_s;
  logic [2:0]       r_disp_e;
  logic [3:0]       r_disp_f;
  logic             r_updated;

  logic             w_tc;
  logic             w_fb;
  logic             w_accept;
  logic [3:0]       w_an;
  logic [6:0]       w_seg;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign w_tc     = (r_refresh_cnt == c_cnt_last);
  assign w_fb     = w_tc && (r_dig_idx == 2'd3);
  assign w_accept = in_valid && !r_pend_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refresh_cnt <= '0;
      r_dig_idx     <= 2'd0;
    end else if (w_tc) begin
      r_refresh_cnt <= '0;
      r_dig_idx     <= r_dig_idx + 2'd1;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + 1'b1;
    end
  end

  // Accept needs the buffer empty and transfer needs it full, so the two
  // branches are mutually exclusive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_valid <= 1'b0;
      r_pend       <= 8'd0;
      r_disp_s     <= 1'b0;
      r_disp_e     <= 3'd0;
      r_disp_f     <= 4'd0;
      r_updated    <= 1'b0;
    end else begin
      r_updated <= 1'b0;
      if (w_accept) begin
        r_pend       <= {S, E, F};
        r_pend_valid <= 1'b1;
      end else if (w_fb && r_pend_valid) begin
        {r_disp_s, r_disp_e, r_disp_f} <= r_pend;
        r_pend_valid <= 1'b0;
        r_updated    <= 1'b1;
      end
    end
  end

  always_comb begin
    w_an            = 4'b1111;
    w_an[r_dig_idx] = 1'b0;
  end

  always_comb begin
    w_seg = c_seg_blank;
    case (r_dig_idx)
      2'd3:    w_seg = r_disp_s ? c_seg_minus : c_seg_blank;
      2'd2:    w_seg = hex7(r_disp_f);
      2'd1:    w_seg = c_seg_e;
      default: w_seg = hex7({1'b0, r_disp_e});
    endcase
  end

  assign in_ready = !r_pend_valid;
  assign an       = w_an;
  assign seg      = w_seg;
  assign updated  = r_updated;

endmodule
`default_nettype wire

// File: tb/tb_fp_result_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_result_display
//  Purpose  : Self-checking bench for fp_result_display with REFRESH_DIV = 4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_result_display;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       S;
  logic [2:0] E;
  logic [3:0] F;
  logic [3:0] an;
  logic [6:0] seg;
  logic       updated;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  fp_result_display #(.REFRESH_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .S        (S),
    .E        (E),
    .F        (F),
    .an       (an),
    .seg      (seg),
    .updated  (updated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        s;
    logic [2:0]  e;
    logic [3:0]  f;
    logic [27:0] pat;   // {idx3, idx2, idx1, idx0} segment patterns
  } vec_t;

  vec_t tbl [16];

  localparam logic [27:0] c_pat_zero = {7'b1111111, 7'b1000000, 7'b0000110, 7'b1000000};

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  function automatic logic [27:0] pat_of(input logic [7:0] v);
    pat_of = {(v[7] ? 7'b0111111 : 7'b1111111), hex7(v[3:0]), 7'b0000110, hex7({1'b0, v[6:4]})};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Digit position follows from cycles since reset release: 4 cycles per digit.
  task automatic chk_digit(input string name, input logic [27:0] pat);
    int idx;
    logic [3:0] exp_an;
    idx    = (cyc % 16) / 4;
    exp_an = 4'b1111;
    exp_an[idx] = 1'b0;
    chk({name, "_an"}, 32'(an), 32'(exp_an));
    chk({name, "_seg"}, 32'(seg), 32'(pat[idx*7 +: 7]));
  endtask

  task automatic chk_frame(input string name, input logic [27:0] pat);
    for (int i = 0; i < 16; i++) begin
      chk_digit(name, pat);
      if (i != 0) chk({name, "_upd0"}, 32'(updated), 32'd0);
      step();
    end
  endtask

  initial begin
    logic [7:0]  q[$];
    logic [7:0]  exp_disp;
    logic [27:0] pat_a;
    logic [27:0] pat_b;
    int          n;
    int          sent;
    int          upd_cnt;
    int          guard;
    bit          acc;

    tbl[0]  = '{1'b1, 3'd3, 4'hB, {7'b0111111, 7'b0000011, 7'b0000110, 7'b0110000}};
    tbl[1]  = '{1'b0, 3'd7, 4'hF, {7'b1111111, 7'b0001110, 7'b0000110, 7'b1111000}};
    tbl[2]  = '{1'b0, 3'd0, 4'h0, {7'b1111111, 7'b1000000, 7'b0000110, 7'b1000000}};
    tbl[3]  = '{1'b1, 3'd1, 4'h1, {7'b0111111, 7'b1111001, 7'b0000110, 7'b1111001}};
    tbl[4]  = '{1'b0, 3'd2, 4'h2, {7'b1111111, 7'b0100100, 7'b0000110, 7'b0100100}};
    tbl[5]  = '{1'b1, 3'd4, 4'h3, {7'b0111111, 7'b0110000, 7'b0000110, 7'b0011001}};
    tbl[6]  = '{1'b0, 3'd5, 4'h4, {7'b1111111, 7'b0011001, 7'b0000110, 7'b0010010}};
    tbl[7]  = '{1'b1, 3'd6, 4'h5, {7'b0111111, 7'b0010010, 7'b0000110, 7'b0000010}};
    tbl[8]  = '{1'b0, 3'd0, 4'h6, {7'b1111111, 7'b0000010, 7'b0000110, 7'b1000000}};
    tbl[9]  = '{1'b1, 3'd7, 4'h7, {7'b0111111, 7'b1111000, 7'b0000110, 7'b1111000}};
    tbl[10] = '{1'b0, 3'd1, 4'h8, {7'b1111111, 7'b0000000, 7'b0000110, 7'b1111001}};
    tbl[11] = '{1'b1, 3'd2, 4'h9, {7'b0111111, 7'b0010000, 7'b0000110, 7'b0100100}};
    tbl[12] = '{1'b0, 3'd3, 4'hA, {7'b1111111, 7'b0001000, 7'b0000110, 7'b0110000}};
    tbl[13] = '{1'b1, 3'd5, 4'hC, {7'b0111111, 7'b1000110, 7'b0000110, 7'b0010010}};
    tbl[14] = '{1'b0, 3'd4, 4'hD, {7'b1111111, 7'b0100001, 7'b0000110, 7'b0011001}};
    tbl[15] = '{1'b1, 3'd6, 4'hE, {7'b0111111, 7'b0000110, 7'b0000110, 7'b0000010}};
    pat_a = tbl[0].pat;
    pat_b = tbl[1].pat;

    rst = 1'b1; in_valid = 1'b0; S = 1'b0; E = 3'd0; F = 4'd0;

    // Reset values while held in reset, then release at a falling edge.
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'(4'b1110));
    chk("rst_seg", 32'(seg), 32'(7'b1000000));
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_upd", 32'(updated), 32'd0);
    rst = 1'b0;
    cyc = 0;

    // Scan order across two frames.
    for (int i = 0; i < 32; i++) begin
      chk_digit("scan", c_pat_zero);
      step();
    end

    // Accept at frame start; a second value is held while the buffer is full.
    S = 1'b1; E = 3'd3; F = 4'hB; in_valid = 1'b1;
    chk("t2_ready_pre", 32'(in_ready), 32'd1);
    step();
    S = 1'b0; E = 3'd7; F = 4'hF;
    do begin
      chk("t2_ready_full", 32'(in_ready), 32'd0);
      chk("t2_upd_early", 32'(updated), 32'd0);
      chk_digit("t2_old", c_pat_zero);
      step();
    end while (cyc < 48);
    chk("t2_upd_fb", 32'(updated), 32'd1);
    chk("t2_ready_after", 32'(in_ready), 32'd1);
    chk_digit("t2_new", pat_a);
    step();
    in_valid = 1'b0;
    chk("t3_ready_acc", 32'(in_ready), 32'd0);
    chk("t2_upd_once", 32'(updated), 32'd0);
    while (cyc < 64) begin
      chk_digit("t2_frame", pat_a);
      chk("t3_upd_early", 32'(updated), 32'd0);
      step();
    end
    chk("t3_upd_fb", 32'(updated), 32'd1);
    chk_frame("t3_frame", pat_b);

    // Table-driven vectors: one value per frame.
    for (int v = 0; v < 16; v++) begin
      chk($sformatf("tbl%0d_ready", v), 32'(in_ready), 32'd1);
      S = tbl[v].s; E = tbl[v].e; F = tbl[v].f; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n = 0;
      while (!updated && n < 40) begin
        step();
        n++;
      end
      chk($sformatf("tbl%0d_upd", v), 32'(updated), 32'd1);
      chk_frame($sformatf("tbl%0d", v), tbl[v].pat);
    end

    // Reset with a value pending: it must never reach the display.
    S = 1'b1; E = 3'd5; F = 4'h8; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    #2 rst = 1'b1;
    #1;
    chk("t5_an", 32'(an), 32'(4'b1110));
    chk("t5_seg", 32'(seg), 32'(7'b1000000));
    chk("t5_ready", 32'(in_ready), 32'd1);
    chk("t5_upd", 32'(updated), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    #2;
    chk("t5_hold_an", 32'(an), 32'(4'b1110));
    chk("t5_hold_seg", 32'(seg), 32'(7'b1000000));
    for (int i = 0; i < 40; i++) begin
      chk("t5_no_upd", 32'(updated), 32'd0);
      chk_digit("t5_zero", c_pat_zero);
      step();
    end

    // Random stream: every accepted value appears once, in order.
    exp_disp = 8'd0;
    sent = 0; upd_cnt = 0; guard = 0;
    while (!(sent == 500 && q.size() == 0) && guard < 30000) begin
      if (updated) begin
        upd_cnt++;
        if (q.size() == 0) begin
          chk("t6_spurious_upd", 32'd1, 32'd0);
        end else begin
          exp_disp = q.pop_front();
        end
      end
      chk_digit("t6", pat_of(exp_disp));
      if (!in_valid && sent < 500 && $urandom_range(0, 3) == 0) begin
        S = 1'($urandom); E = 3'($urandom); F = 4'($urandom);
        in_valid = 1'b1;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        q.push_back({S, E, F});
        sent++;
      end
      step();
      if (acc) in_valid = 1'b0;
      guard++;
    end
    chk("t6_timeout", 32'(guard < 30000), 32'd1);
    chk("t6_accepts", 32'(sent), 32'd500);
    chk("t6_updates", 32'(upd_cnt), 32'd500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
